nbcac_decode_arbiter: RTL and testbench

NBCAC_DECODE_ARBITER -- requirements
Module: nbcac_decode_arbiter

---
 rtl/nbcac_decode_arbiter.sv | 129 ++++++++++++
 tb/tb_nbcac_decode_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nbcac_decode_arbiter.sv
// nbcac_decode_arbiter: round-robin arbiter that feeds NUM_CH codeword
// requesters into one shared nbcac_22di_decoder_core and a single
// registered output stage with valid/ready handshake.
//
// nbcac_22di_decoder_core: single-error-correcting decoder for a
// Hamming(31,26) code. Codeword bit (p-1) holds code position p (1..31);
// positions 1,2,4,8,16 are parity. Data bit k sits at the k-th
// non-power-of-two position; only the first DW of those carry payload.

module nbcac_22di_decoder_core #(
    parameter int CW = 31,
    parameter int DW = 22
) (
    input  logic [CW-1:0] code,
    output logic [DW-1:0] data
);
    localparam int SW = $clog2(CW + 1);

    logic [SW-1:0] syn;
    logic [CW-1:0] fixed;

    // Syndrome is the XOR of the positions of all set bits; nonzero points
    // straight at the single flipped position.
    always_comb begin
        syn = '0;
        for (int p = 1; p <= CW; p++) begin
            if (code[p-1]) syn = syn ^ SW'(p);
        end
        fixed = code;
        if (syn != '0) fixed[syn - SW'(1)] = ~code[syn - SW'(1)];
    end

    // Gather payload bits from the non-parity positions in ascending order.
    always_comb begin
        int k;
        data = '0;
        k = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k < DW) data[k] = fixed[p-1];
                k = k + 1;
            end
        end
    end
endmodule

module nbcac_decode_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CW     = 31,
    parameter int DW     = 22,
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*CW-1:0] in_code,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [CHW-1:0]       out_ch,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);
    logic [CHW-1:0]    last_grant;
    logic [CHW-1:0]    gidx;
    logic              found;
    logic [CW-1:0]     sel_code;
    logic [DW-1:0]     dec_data;
    logic              stage_free;
    logic              grant;
    logic              xfer;

    assign stage_free = !out_valid || out_ready;
    assign grant      = !rst && cfg_en && stage_free && found;

    // Round-robin search from last_grant+1 upward with wrap; first requester
    // wins and its codeword is steered to the shared decoder.
    always_comb begin
        int idx;
        found    = 1'b0;
        gidx     = '0;
        sel_code = in_code[CW-1:0];
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(last_grant) + 1 + k) % NUM_CH;
            if (!found && in_valid[idx]) begin
                found    = 1'b1;
                gidx     = CHW'(idx);
                sel_code = in_code[idx*CW +: CW];
            end
        end
    end

    // One-hot accept for the winner only when a grant may be issued.
    always_comb begin
        in_ready = '0;
        if (grant) in_ready[gidx] = 1'b1;
    end

    // in_ready already implies in_valid for the winner.
    assign xfer = grant;

    nbcac_22di_decoder_core #(
        .CW (CW),
        .DW (DW)
    ) u_core (
        .code (sel_code),
        .data (dec_data)
    );

    // Output stage: load on transfer, drain on consume, hold otherwise.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            xfer_cnt   <= '0;
            last_grant <= CHW'(NUM_CH - 1);
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= dec_data;
            out_ch     <= gidx;
            xfer_cnt   <= xfer_cnt + 16'd1;
            last_grant <= gidx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nbcac_decode_arbiter.sv
// Directed bench for nbcac_decode_arbiter: grant order, stall/hold, decode
// correctness with single-bit errors, enable gating, counter wrap, reset.

module tb_nbcac_decode_arbiter;
    localparam int NUM_CH = 4;
    localparam int CW     = 31;
    localparam int DW     = 22;

    logic               clock = 1'b0;
    logic               rst;
    logic               cfg_en;
    logic [NUM_CH-1:0]  in_valid;
    logic [NUM_CH*CW-1:0] in_code;
    logic [NUM_CH-1:0]  in_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [1:0]         out_ch;
    logic               out_ready;
    logic [15:0]        xfer_cnt;

    int checks = 0;
    int errors = 0;

    nbcac_decode_arbiter #(.NUM_CH(NUM_CH), .CW(CW), .DW(DW)) dut (
        .clock     (clock),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hamming(31,26) encoder: payload in non-power-of-two positions, parity
    // bits chosen so the overall syndrome is zero.
    function automatic logic [30:0] enc(input logic [21:0] d);
        logic [30:0] c;
        logic        par;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p <= 31; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k < 22) c[p-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            par = 1'b0;
            for (int p = 1; p <= 31; p++)
                if (((p >> j) & 1) == 1 && p != (1 << j)) par ^= c[p-1];
            c[(1 << j) - 1] = par;
        end
        return c;
    endfunction

    logic [21:0] dv [NUM_CH];
    logic [3:0]  exp_rdy [5];
    logic [21:0] r;
    logic [30:0] cw_v;
    int          exp_cnt;
    int          nfill;

    initial begin
        dv[0] = 22'h0ABCDE; dv[1] = 22'h135724; dv[2] = 22'h3FFFFF; dv[3] = 22'h000001;
        exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
        exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
        rst = 1'b1; cfg_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) in_code[i*CW +: CW] = enc(dv[i]);

        // Reset state; in_ready suppressed while rst is high
        step(); step();
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);

        // Round robin with all channels requesting
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_in_ready", in_ready, exp_rdy[i]);
            step();
            exp_cnt++;
            chk("rr_out_valid", out_valid, 1);
            chk("rr_out_ch", out_ch, i % 4);
            chk("rr_out_data", out_data, dv[i % 4]);
        end
        chk("rr_xfer_cnt", xfer_cnt, 5);
        in_valid = 4'b0000;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_ch_kept", out_ch, 0);
        chk("drain_data_kept", out_data, dv[0]);

        // ch2 transfers, then 3-cycle stall with ch1 and ch3 pending
        in_valid = 4'b0100;
        #1 chk("st_in_ready", in_ready, 4'b0100);
        step(); exp_cnt++;
        chk("st_out_ch", out_ch, 2);
        out_ready = 1'b0; in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready, 4'b0000);
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_ch", out_ch, 2);
            chk("stall_data", out_data, dv[2]);
        end
        out_ready = 1'b1;
        #1 chk("unstall_in_ready", in_ready, 4'b1000);
        step(); exp_cnt++;
        chk("unstall_ch", out_ch, 3);
        chk("unstall_data", out_data, dv[3]);
        chk("unstall_cnt", xfer_cnt, exp_cnt);
        in_valid = 4'b0000;
        step();

        // Random payloads on ch1, some with a single flipped bit
        in_valid = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            r = 22'($urandom);
            cw_v = enc(r);
            if ($urandom_range(0, 1) == 1) cw_v[$urandom_range(0, 30)] ^= 1'b1;
            in_code[1*CW +: CW] = cw_v;
            #1 chk("rnd_in_ready", in_ready, 4'b0010);
            step(); exp_cnt++;
            chk("rnd_valid", out_valid, 1);
            chk("rnd_data", out_data, r);
        end
        chk("rnd_cnt", xfer_cnt, exp_cnt);

        // Disable while a word is held: it drains, nothing new granted
        cfg_en = 1'b0; in_valid = 4'b1111;
        #1 chk("dis_in_ready0", in_ready, 4'b0000);
        step();
        chk("dis_drain", out_valid, 0);
        for (int i = 0; i < 2; i++) begin
            chk("dis_in_ready", in_ready, 4'b0000);
            step();
        end
        chk("dis_cnt", xfer_cnt, exp_cnt);
        cfg_en = 1'b1;
        #1 chk("en_in_ready", in_ready, 4'b0100);
        step(); exp_cnt++;
        chk("en_out_ch", out_ch, 2);
        chk("en_cnt", xfer_cnt, exp_cnt);
        in_valid = 4'b0000;
        step();

        // Counter wrap
        in_valid = 4'b0001;
        nfill = 16'hFFFE - exp_cnt;
        repeat (nfill) @(posedge clock);
        #1;
        chk("wrap_fffe", xfer_cnt, 16'hFFFE);
        step();
        chk("wrap_ffff", xfer_cnt, 16'hFFFF);
        step();
        chk("wrap_0000", xfer_cnt, 16'h0000);

        // Mid-operation reset with last_grant=1 and a held word
        in_valid = 4'b0010;
        #1 chk("pre_rst_in_ready", in_ready, 4'b0010);
        step();
        chk("pre_rst_ch", out_ch, 1);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1; out_ready = 1'b0; in_valid = 4'b1111;
        #1 chk("mid_rst_in_ready", in_ready, 4'b0000);
        step();
        rst = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_cnt", xfer_cnt, 0);
        chk("post_rst_ch", out_ch, 0);
        out_ready = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 4'b0001);
        step();
        chk("post_rst_grant_ch", out_ch, 0);
        chk("post_rst_data", out_data, dv[0]);
        chk("post_rst_cnt1", xfer_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
